// File: rtl/lc3b_types.sv
// Shared LC-3b front-end types: machine word, BTB update payload and BTB geometry helpers.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  localparam int unsigned BTB_IDX_W = 3;

  typedef struct packed {
    lc3b_word pc;
    lc3b_word target;
    logic     taken;
  } btb_update_t;

  // Tag covers pc[15:idx_w+1]; pc[0] never participates.
  function automatic int unsigned btb_tag_w(input int unsigned idx_w);
    return 15 - idx_w;
  endfunction

endpackage

// File: rtl/btb_update_fifo.sv
// Synchronous FIFO for BTB resolution updates; pushes to a full FIFO and pops from an empty one are ignored.
module btb_update_fifo #(
  parameter int unsigned W     = 33,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB port arbiter: fetch lookups own the single array port; queued WB updates drain on idle or starved cycles.
module btb_update_ctrl
  import lc3b_types::*;
#(
  parameter int unsigned IDX_W      = BTB_IDX_W,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 7
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          lookup_valid,
  input  logic [15:0]                   lookup_pc,
  output logic                          lookup_hit,
  output logic [15:0]                   lookup_target,
  input  logic                          update_valid,
  input  logic [15:0]                   update_pc,
  input  logic [15:0]                   update_target,
  input  logic                          update_taken,
  output logic                          update_ready,
  output logic [IDX_W-1:0]              btb_addr,
  output logic                          btb_we,
  output logic                          btb_wvalid,
  output logic [btb_tag_w(IDX_W)-1:0]   btb_wtag,
  output logic [15:0]                   btb_wtarget,
  input  logic                          btb_rvalid,
  input  logic [btb_tag_w(IDX_W)-1:0]   btb_rtag,
  input  logic [15:0]                   btb_rtarget,
  output logic                          init_done
);

  localparam int unsigned UPD_W = $bits(btb_update_t);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned SV_W  = $clog2(STARVE_MAX + 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            state;
  logic [IDX_W-1:0]  sweep_cnt;
  logic [SV_W-1:0]   starve_cnt;
  logic [UPD_W-1:0]  fifo_rdata;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  btb_update_t       head;
  btb_update_t       upd_in;
  logic              write_cyc_c;
  logic              unused_ok;

  assign upd_in    = '{pc: update_pc, target: update_target, taken: update_taken};
  assign head      = btb_update_t'(fifo_rdata);
  assign unused_ok = ^{lookup_pc[0], head.pc[0]};

  // Updates are accepted during the sweep too; they simply wait for RUN.
  assign update_ready = !reset && !fifo_full;
  assign fifo_push    = update_valid && update_ready;
  assign init_done    = !reset && (state == ST_RUN);

  // Drain on an idle fetch port, or steal the port once the head has waited long enough.
  assign write_cyc_c = !reset && (state == ST_RUN) && !fifo_empty &&
                       (!lookup_valid || (starve_cnt == SV_W'(STARVE_MAX)));

  btb_update_fifo #(
    .W     (UPD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (write_cyc_c),
    .wdata (UPD_W'(upd_in)),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Sweep sequencing and starvation tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_INIT;
      sweep_cnt  <= '0;
      starve_cnt <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          sweep_cnt <= sweep_cnt + IDX_W'(1);
          if (sweep_cnt == '1) state <= ST_RUN;
        end
        ST_RUN: begin
          if ((fifo_count == '0) || write_cyc_c) begin
            starve_cnt <= '0;
          end else if (starve_cnt != SV_W'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + SV_W'(1);
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // Array port mux and hit qualification; everything reads zero while reset is held.
  always_comb begin
    btb_addr      = '0;
    btb_we        = 1'b0;
    btb_wvalid    = 1'b0;
    btb_wtag      = '0;
    btb_wtarget   = '0;
    lookup_hit    = 1'b0;
    lookup_target = '0;
    if (!reset) begin
      if (state == ST_INIT) begin
        btb_we   = 1'b1;
        btb_addr = sweep_cnt;
      end else if (write_cyc_c) begin
        btb_we      = 1'b1;
        btb_addr    = head.pc[IDX_W:1];
        btb_wvalid  = head.taken;
        btb_wtag    = head.pc[15:IDX_W+1];
        btb_wtarget = head.target;
      end else begin
        btb_addr   = lookup_pc[IDX_W:1];
        lookup_hit = lookup_valid && btb_rvalid && (btb_rtag == lookup_pc[15:IDX_W+1]);
        if (lookup_hit) lookup_target = btb_rtarget;
      end
    end
  end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Bench for btb_update_ctrl: directed scenarios then random traffic, checked every cycle against a queue-based model.
module tb_btb_update_ctrl;

  localparam int unsigned IDX_W      = 3;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned STARVE_MAX = 7;
  localparam int unsigned TAG_W      = 15 - IDX_W;
  localparam int          N          = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              lookup_valid = 1'b0;
  logic [15:0]       lookup_pc = '0;
  logic              lookup_hit;
  logic [15:0]       lookup_target;
  logic              update_valid = 1'b0;
  logic [15:0]       update_pc = '0;
  logic [15:0]       update_target = '0;
  logic              update_taken = 1'b0;
  logic              update_ready;
  logic [IDX_W-1:0]  btb_addr;
  logic              btb_we;
  logic              btb_wvalid;
  logic [TAG_W-1:0]  btb_wtag;
  logic [15:0]       btb_wtarget;
  logic              btb_rvalid;
  logic [TAG_W-1:0]  btb_rtag;
  logic [15:0]       btb_rtarget;
  logic              init_done;

  btb_update_ctrl #(
    .IDX_W      (IDX_W),
    .DEPTH      (DEPTH),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .lookup_valid  (lookup_valid),
    .lookup_pc     (lookup_pc),
    .lookup_hit    (lookup_hit),
    .lookup_target (lookup_target),
    .update_valid  (update_valid),
    .update_pc     (update_pc),
    .update_target (update_target),
    .update_taken  (update_taken),
    .update_ready  (update_ready),
    .btb_addr      (btb_addr),
    .btb_we        (btb_we),
    .btb_wvalid    (btb_wvalid),
    .btb_wtag      (btb_wtag),
    .btb_wtarget   (btb_wtarget),
    .btb_rvalid    (btb_rvalid),
    .btb_rtag      (btb_rtag),
    .btb_rtarget   (btb_rtarget),
    .init_done     (init_done)
  );

  always #5 clk = ~clk;

  // BTB storage: combinational read, written on the clock; filled with valid garbage while reset is held.
  logic             mem_v [N];
  logic [TAG_W-1:0] mem_t [N];
  logic [15:0]      mem_g [N];
  logic [2:0]       scr_i = '0;

  assign btb_rvalid  = mem_v[btb_addr];
  assign btb_rtag    = mem_t[btb_addr];
  assign btb_rtarget = mem_g[btb_addr];

  always @(posedge clk) begin
    if (btb_we) begin
      mem_v[btb_addr] <= btb_wvalid;
      mem_t[btb_addr] <= btb_wtag;
      mem_g[btb_addr] <= btb_wtarget;
    end else if (reset) begin
      mem_v[scr_i] <= 1'b1;
      mem_t[scr_i] <= TAG_W'($urandom);
      mem_g[scr_i] <= 16'($urandom);
      scr_i        <= scr_i + 3'd1;
    end
  end

  // Reference model: pending updates in arrival order plus the expected array contents.
  typedef struct {
    int pc;
    int target;
    bit taken;
  } upd_t;

  upd_t q[$];
  bit   m_init;
  int   m_sweep;
  int   m_starve;
  bit   m_v [N];
  int   m_tag [N];
  int   m_tgt [N];

  int e_we, e_addr, e_wvalid, e_wtag, e_wtarget, e_hit, e_target, e_ready, e_done, e_write;
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Mid-cycle: derive this cycle's expected outputs and compare.
  task automatic settle();
    int idx;
    @(negedge clk);
    e_we = 0; e_addr = 0; e_wvalid = 0; e_wtag = 0; e_wtarget = 0;
    e_hit = 0; e_target = 0; e_write = 0;
    e_ready = (!reset && q.size() < DEPTH) ? 1 : 0;
    e_done  = (!reset && !m_init) ? 1 : 0;
    if (!reset) begin
      if (m_init) begin
        e_we   = 1;
        e_addr = m_sweep;
      end else if (q.size() > 0 && (!lookup_valid || m_starve >= STARVE_MAX)) begin
        e_write   = 1;
        e_we      = 1;
        e_addr    = (q[0].pc >> 1) % N;
        e_wvalid  = int'(q[0].taken);
        e_wtag    = q[0].pc >> (IDX_W + 1);
        e_wtarget = q[0].target;
      end else begin
        idx    = (int'(lookup_pc) >> 1) % N;
        e_addr = idx;
        if (lookup_valid && m_v[idx] && m_tag[idx] == (int'(lookup_pc) >> (IDX_W + 1))) begin
          e_hit    = 1;
          e_target = m_tgt[idx];
        end
      end
    end
    chk("btb_we", 32'(btb_we), e_we);
    chk("btb_addr", 32'(btb_addr), e_addr);
    if (e_we == 1) begin
      chk("btb_wvalid", 32'(btb_wvalid), e_wvalid);
      chk("btb_wtag", 32'(btb_wtag), e_wtag);
      chk("btb_wtarget", 32'(btb_wtarget), e_wtarget);
    end
    chk("lookup_hit", 32'(lookup_hit), e_hit);
    chk("lookup_target", 32'(lookup_target), e_target);
    chk("update_ready", 32'(update_ready), e_ready);
    chk("init_done", 32'(init_done), e_done);
  endtask

  // Clock edge: advance the model with the inputs that were stable across the edge.
  task automatic tick();
    int  idx;
    int  qs;
    bit  push;
    @(posedge clk);
    if (reset) begin
      m_init   = 1;
      m_sweep  = 0;
      m_starve = 0;
      q.delete();
    end else begin
      push = update_valid && (e_ready == 1);
      qs   = q.size();
      if (m_init) begin
        m_v[m_sweep] = 0;
        m_sweep++;
        if (m_sweep == N) m_init = 0;
      end else if (e_write == 1) begin
        idx        = (q[0].pc >> 1) % N;
        m_v[idx]   = q[0].taken;
        m_tag[idx] = q[0].pc >> (IDX_W + 1);
        m_tgt[idx] = q[0].target;
        void'(q.pop_front());
        m_starve = 0;
      end else if (qs > 0) begin
        m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
      end else begin
        m_starve = 0;
      end
      if (push) q.push_back('{int'(update_pc), int'(update_target), update_taken});
    end
    #1;
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  function automatic logic [15:0] pick_pc();
    int tags [3];
    tags[0] = 'h300; tags[1] = 'h301; tags[2] = 'habc;
    return 16'((tags[$urandom_range(0, 2)] << 4) | ($urandom_range(0, 7) << 1) | $urandom_range(0, 1));
  endfunction

  initial begin
    int prev_we;
    int accepted;

    repeat (10) cyc();

    // Sweep: addresses 0..7 written invalid, no hits, init_done on the ninth cycle.
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      lookup_valid = 1'b1;
      lookup_pc    = 16'($urandom);
      settle();
      chk("sweep_addr", 32'(btb_addr), i);
      chk("sweep_we", 32'(btb_we), 1);
      chk("sweep_hit", 32'(lookup_hit), 0);
      tick();
    end
    lookup_valid = 1'b0;
    settle();
    chk("init_done_rise", 32'(init_done), 1);
    tick();

    // Install then hit.
    update_valid = 1'b1; update_pc = 16'h3006; update_target = 16'h3020; update_taken = 1'b1;
    cyc();
    update_valid = 1'b0;
    settle();
    chk("install_we", 32'(btb_we), 1);
    chk("install_addr", 32'(btb_addr), 3);
    chk("install_wtag", 32'(btb_wtag), 'h300);
    chk("install_wtarget", 32'(btb_wtarget), 'h3020);
    tick();
    lookup_valid = 1'b1; lookup_pc = 16'h3006;
    settle();
    chk("install_hit", 32'(lookup_hit), 1);
    chk("install_target", 32'(lookup_target), 'h3020);
    tick();
    lookup_pc = 16'h4006;
    settle();
    chk("other_tag_miss", 32'(lookup_hit), 0);
    tick();

    // Invalidate.
    lookup_valid = 1'b0;
    update_valid = 1'b1; update_pc = 16'h3006; update_taken = 1'b0;
    cyc();
    update_valid = 1'b0;
    settle();
    chk("inval_wvalid", 32'(btb_wvalid), 0);
    tick();
    lookup_valid = 1'b1; lookup_pc = 16'h3006;
    settle();
    chk("inval_miss", 32'(lookup_hit), 0);
    tick();

    // Starvation: reinstall 0x3006, then one update behind a constant lookup stream.
    lookup_valid = 1'b0;
    update_valid = 1'b1; update_pc = 16'h3006; update_target = 16'h3020; update_taken = 1'b1;
    cyc();
    update_valid = 1'b0;
    cyc();
    lookup_valid = 1'b1; lookup_pc = 16'h3006;
    update_valid = 1'b1; update_pc = 16'h3102; update_target = 16'h3200; update_taken = 1'b1;
    cyc();
    update_valid = 1'b0;
    for (int i = 0; i < STARVE_MAX; i++) begin
      settle();
      chk("starve_lookup_we", 32'(btb_we), 0);
      chk("starve_lookup_hit", 32'(lookup_hit), 1);
      tick();
    end
    settle();
    chk("starve_force_we", 32'(btb_we), 1);
    chk("starve_force_hit", 32'(lookup_hit), 0);
    tick();

    // Backpressure: fill the FIFO, then hold a fifth update until the first forced pop.
    for (int i = 0; i < DEPTH; i++) begin
      update_valid = 1'b1; update_pc = 16'(16'h5000 + 2 * i); update_target = 16'(16'h6000 + i);
      cyc();
    end
    update_pc = 16'h5010; update_target = 16'h6010;
    settle();
    chk("bp_full_ready", 32'(update_ready), 0);
    tick();
    prev_we  = 0;
    accepted = 0;
    for (int i = 0; i < 16 && accepted == 0; i++) begin
      settle();
      if (update_ready) begin
        accepted = 1;
        chk("bp_accept_after_pop", prev_we, 1);
      end
      prev_we = int'(btb_we);
      tick();
    end
    chk("bp_accepted", accepted, 1);
    update_valid = 1'b0;
    lookup_valid = 1'b0;
    repeat (6) cyc();

    // Mid-operation reset with three queued updates.
    lookup_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      update_valid = 1'b1; update_pc = 16'(16'h7002 + 2 * i);
      cyc();
    end
    update_valid = 1'b0;
    reset = 1'b1;
    settle();
    chk("rst_we", 32'(btb_we), 0);
    chk("rst_ready", 32'(update_ready), 0);
    tick();
    reset = 1'b0;
    settle();
    chk("rst_sweep_addr0", 32'(btb_addr), 0);
    chk("rst_sweep_we", 32'(btb_we), 1);
    tick();
    repeat (N - 1) cyc();
    lookup_valid = 1'b0;
    settle();
    chk("rst_no_stale_write", 32'(btb_we), 0);
    tick();

    // Random traffic with occasional resets.
    for (int c = 0; c < 600; c++) begin
      reset         = ($urandom_range(0, 199) == 0);
      lookup_valid  = ($urandom_range(0, 3) != 0);
      lookup_pc     = pick_pc();
      update_valid  = ($urandom_range(0, 2) == 0);
      update_pc     = pick_pc();
      update_target = 16'($urandom);
      update_taken  = ($urandom_range(0, 3) != 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
